// File: rtl/execute_mc_if.sv
// Operation/result handshake bundle for execute_mc.
//   master : the side issuing operations and consuming results (testbench / pipeline).
//   slave  : the execute unit itself.
// Signals:
//   in_valid/in_ready              operation request handshake
//   op, rs1_addr, rs2_addr, rd_addr, imm, alu_src, wb_en   operation fields
//   wr_en, wr_addr, wr_data        external register-file preload port
//   out_valid/out_ready            result handshake
//   result, zero_flag, busy        result value, result==0, multi-cycle op running
interface execute_mc_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic            wb_en;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero_flag;
    logic            busy;

    modport master (
        output in_valid, op, rs1_addr, rs2_addr, rd_addr, imm, alu_src, wb_en,
        output wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, result, zero_flag, busy
    );

    modport slave (
        input  in_valid, op, rs1_addr, rs2_addr, rd_addr, imm, alu_src, wb_en,
        input  wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, result, zero_flag, busy
    );
endinterface

// File: rtl/execute_mc.sv
// execute_mc: execute unit with a private register file.
// Single-cycle ALU ops (ADD..SLTU) complete one cycle after accept; MUL, MULHU,
// DIVU and REMU iterate one bit per cycle for XLEN cycles (shift-add multiply,
// restoring divide) sharing one pair of accumulator registers.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears FSM, result, counter, registers)
//   bus  execute_mc_if.slave: request, preload write port and result handshake
module execute_mc #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    execute_mc_if.slave  bus
);
    localparam int AW  = $clog2(NREG);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] rf_reg [NREG];
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] acc_hi_reg;   // product high half / partial remainder
    logic [XLEN-1:0] acc_lo_reg;   // multiplier->product low half / dividend->quotient
    logic [XLEN-1:0] opb_reg;      // multiplicand / divisor
    logic [3:0]      op_reg;
    logic [AW-1:0]   rd_reg;
    logic            wb_en_reg;
    logic [CW-1:0]   cnt_reg;

    // Operand read straight from the array at accept: a write landing on the
    // same edge is not forwarded, so the pre-write value is used.
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] opb;
    logic [SHW-1:0]  shamt;
    logic            is_muldiv;
    logic [XLEN-1:0] alu_res;

    assign opa       = rf_reg[bus.rs1_addr];
    assign rs2_val   = rf_reg[bus.rs2_addr];
    assign opb       = bus.alu_src ? bus.imm : rs2_val;
    assign shamt     = opb[SHW-1:0];
    assign is_muldiv = (MULDIV_EN != 0) && (bus.op >= 4'd10) && (bus.op <= 4'd13);

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'd0:    alu_res = opa + opb;
            4'd1:    alu_res = opa - opb;
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = opa << shamt;
            4'd6:    alu_res = opa >> shamt;
            4'd7:    alu_res = $unsigned($signed(opa) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            default: alu_res = '0;   // reserved codes, and muldiv when disabled
        endcase
    end

    // One iteration of the shared multiply/divide datapath.
    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;
    logic [XLEN-1:0] md_res;

    always_comb begin
        is_div    = (op_reg == 4'd12) || (op_reg == 4'd13);
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_reg};
        // No borrow means the divisor fits. A zero divisor always fits, which
        // yields an all-ones quotient and leaves the dividend as remainder.
        div_ge    = ~div_diff[XLEN];
        if (is_div) begin
            hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {acc_lo_reg[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end
        // MULHU (11) and REMU (13) take the high half.
        md_res = op_reg[0] ? hi_next : lo_next;
    end

    logic out_fire;
    assign out_fire = (state_reg == DONE) && bus.out_ready;

    // Register file. Preload write is placed after writeback so it wins a
    // same-register collision; register 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            if (out_fire && wb_en_reg && (rd_reg != '0)) begin
                rf_reg[rd_reg] <= result_reg;
            end
            if (bus.wr_en && (bus.wr_addr != '0)) begin
                rf_reg[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            wb_en_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg    <= bus.op;
                        rd_reg    <= bus.rd_addr;
                        wb_en_reg <= bus.wb_en;
                        cnt_reg   <= '0;
                        if (is_muldiv) begin
                            acc_hi_reg <= '0;
                            acc_lo_reg <= opa;
                            opb_reg    <= opb;
                            state_reg  <= BUSY;
                        end else begin
                            result_reg <= alu_res;
                            state_reg  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc_hi_reg <= hi_next;
                    acc_lo_reg <= lo_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(XLEN - 1)) begin
                        result_reg <= md_res;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg == BUSY);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.zero_flag = (result_reg == '0);
endmodule

// File: tb/tb_execute_mc.sv
// Testbench for execute_mc: directed steps followed by randomized operations,
// every result checked against a register-file model and arithmetic reference.
module tb_execute_mc;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_mc_if #(.XLEN(XLEN), .NREG(NREG)) bus();

    execute_mc #(.XLEN(XLEN), .NREG(NREG), .MULDIV_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mrf [32];
    logic [31:0] exp_res;
    bit          exp_wb;
    int          exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference semantics straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sh;
        sh = int'(b % 32);
        p  = 64'(a) * 64'(b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return (a[31] && sh != 0) ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return p[31:0];
            11: return p[63:32];
            12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic wr(input int addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        if (addr != 0) mrf[addr] = data;
    endtask

    // Issue one op, wait (bounded) for its result and check it; leaves DONE pending.
    task automatic op_issue(input int op, input int rs1, input int rs2, input int rd,
                            input logic [31:0] imm, input bit alu_src, input bit wb, input string tag);
        logic [31:0] a, b;
        int          cycles, exp_lat;
        bit          busy_bad;
        a        = mrf[rs1];
        b        = alu_src ? imm : mrf[rs2];
        exp_res  = ref_alu(op, a, b);
        exp_lat  = (op >= 10 && op <= 13) ? 33 : 1;
        exp_wb   = wb;
        exp_rd   = rd;
        bus.op       = 4'(op);
        bus.rs1_addr = 5'(rs1);
        bus.rs2_addr = 5'(rs2);
        bus.rd_addr  = 5'(rd);
        bus.imm      = imm;
        bus.alu_src  = alu_src;
        bus.wb_en    = wb;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cycles   = 1;
        busy_bad = 1'b0;
        while (bus.out_valid !== 1'b1 && cycles < 200) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) busy_bad = 1'b1;
            tick();
            cycles++;
        end
        if (exp_lat > 1) chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_zero"}, 32'(bus.zero_flag), (exp_res == 0) ? 32'd1 : 32'd0);
        $display("txn %-14s op=%0d a=0x%08h b=0x%08h rd=%0d wb=%0d -> result=0x%08h lat=%0d",
                 tag, op, a, b, rd, wb, bus.result, cycles);
    endtask

    // Output handshake, optionally with a preload write in the same cycle.
    task automatic op_ack(input bit w, input int waddr, input logic [31:0] wdata);
        bus.out_ready = 1'b1;
        bus.wr_en     = w;
        bus.wr_addr   = 5'(waddr);
        bus.wr_data   = wdata;
        tick();
        bus.out_ready = 1'b0;
        bus.wr_en     = 1'b0;
        if (exp_wb && exp_rd != 0) mrf[exp_rd] = exp_res;
        if (w && waddr != 0) mrf[waddr] = wdata;
        chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
        chk("ack_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input int op, input int rs1, input int rs2, input int rd,
                          input logic [31:0] imm, input bit alu_src, input bit wb, input string tag);
        op_issue(op, rs1, rs2, rd, imm, alu_src, wb, tag);
        op_ack(1'b0, 0, 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bus.in_valid = 0; bus.op = 0; bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rd_addr = 0;
        bus.imm = 0; bus.alu_src = 0; bus.wb_en = 0; bus.wr_en = 0; bus.wr_addr = 0;
        bus.wr_data = 0; bus.out_ready = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero_flag), 32'd1);

        // Basic ALU and writeback
        wr(1, 32'd5);
        wr(2, 32'd3);
        run_op(0, 1, 2, 0, 32'd0, 1'b0, 1'b0, "add");
        run_op(1, 1, 1, 0, 32'd0, 1'b0, 1'b0, "sub_self");
        run_op(0, 1, 0, 3, 32'd4, 1'b1, 1'b1, "addi_wb_x3");
        run_op(0, 3, 0, 0, 32'd0, 1'b0, 1'b0, "add_x3_x0");
        run_op(14, 1, 2, 0, 32'd0, 1'b0, 1'b0, "reserved14");
        run_op(15, 1, 2, 0, 32'd0, 1'b0, 1'b0, "reserved15");
        wr(1, 32'h8000_0000);
        run_op(8, 1, 0, 0, 32'd0, 1'b0, 1'b0, "slt_neg");
        run_op(9, 1, 0, 0, 32'd0, 1'b0, 1'b0, "sltu_big");
        run_op(7, 1, 0, 0, 32'd36, 1'b1, 1'b0, "sra_mask");

        // Multi-cycle ops
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'd3);
        run_op(10, 1, 2, 0, 32'd0, 1'b0, 1'b0, "mul");
        run_op(11, 1, 2, 0, 32'd0, 1'b0, 1'b0, "mulhu");
        wr(1, 32'd100);
        wr(2, 32'd7);
        run_op(12, 1, 2, 0, 32'd0, 1'b0, 1'b0, "divu");
        run_op(13, 1, 2, 0, 32'd0, 1'b0, 1'b0, "remu");
        wr(1, 32'd7);
        wr(2, 32'd0);
        run_op(12, 1, 2, 0, 32'd0, 1'b0, 1'b0, "divu_by0");
        run_op(13, 1, 2, 0, 32'd0, 1'b0, 1'b0, "remu_by0");

        // DONE hold: result stable, new requests ignored; then wr_en wins collision
        wr(1, 32'd11);
        wr(2, 32'd22);
        op_issue(0, 1, 2, 5, 32'd0, 1'b0, 1'b1, "hold_add");
        held = exp_res;
        bus.op = 4'd1; bus.rs1_addr = 5'd2; bus.rs2_addr = 5'd1; bus.rd_addr = 5'd9;
        bus.wb_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            tick();
            chk("hold_result", bus.result, held);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        op_ack(1'b1, 5, 32'h0000_1234);
        run_op(0, 5, 0, 0, 32'd0, 1'b0, 1'b0, "read_x5");
        run_op(0, 9, 0, 0, 32'd0, 1'b0, 1'b0, "read_x9");
        op_issue(4, 1, 2, 7, 32'd0, 1'b0, 1'b1, "xor_wb_x7");
        op_ack(1'b1, 6, 32'h0000_ABCD);
        run_op(0, 6, 0, 0, 32'd0, 1'b0, 1'b0, "read_x6");
        run_op(0, 7, 0, 0, 32'd0, 1'b0, 1'b0, "read_x7");
        run_op(0, 1, 0, 0, 32'd0, 1'b0, 1'b1, "wb_to_x0");

        // Randomized operations
        for (int r = 1; r < 32; r++) wr(r, $urandom);
        for (int i = 0; i < 40; i++) begin
            int          op, rs1, rs2, rd;
            logic [31:0] imm;
            if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 31), $urandom);
            op  = $urandom_range(0, 15);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            rd  = $urandom_range(0, 31);
            case ($urandom_range(0, 5))
                0:       imm = 32'd0;
                1:       imm = 32'hFFFF_FFFF;
                2:       imm = 32'h8000_0000;
                default: imm = $urandom;
            endcase
            run_op(op, rs1, rs2, rd, imm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the middle of a MUL aborts it with no writeback
        wr(1, 32'd5);
        wr(2, 32'd6);
        bus.op = 4'd10; bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd2; bus.rd_addr = 5'd4;
        bus.alu_src = 1'b0; bus.wb_en = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        run_op(0, 1, 0, 0, 32'd0, 1'b0, 1'b0, "abort_x1");
        run_op(0, 4, 0, 0, 32'd0, 1'b0, 1'b0, "abort_x4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width, minimum 8.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two; register 0 reads zero.
REQ-003 SHALL have parameter MULDIV_EN, default 1: 1 enables the iterative multiply/divide ops.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  block can accept an operation.
REQ-008 op  in  4  operation code (Function).
REQ-009 rs1_addr, rs2_addr, rd_addr  in  log2(NREG) each  source and destination registers.
REQ-010 imm  in  XLEN  immediate operand B when alu_src=1.
REQ-011 alu_src  in  1  0: operand B = reg[rs2]; 1: operand B = imm.
REQ-012 wb_en  in  1  write the result to rd at output handshake.
REQ-013 wr_en, wr_addr (log2(NREG)), wr_data (XLEN)  in  external preload write port.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 result  out  XLEN  operation result.
REQ-017 zero_flag  out  1  result == 0.
REQ-018 busy  out  1  multi-cycle op in progress.

Function
REQ-019 SHALL use states IDLE, BUSY, DONE; in_ready=1 only in IDLE, busy=1 only in BUSY, out_valid=1 only in DONE.
REQ-020 SHALL accept an op when in_valid && in_ready, sampling operands, op, rd_addr and wb_en in that cycle.
REQ-021 Operands SHALL be read combinationally at accept, with no bypass of a same-cycle wr_en write (old value used).
REQ-022 Single-cycle ops SHALL go IDLE->DONE; out_valid is asserted the cycle after accept.
REQ-023 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
REQ-024 Shifts SHALL use only B[log2(XLEN)-1:0]; SLT/SLTU SHALL return 1 or 0; arithmetic wraps modulo 2^XLEN.
REQ-025 Op codes: 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned), 12 DIVU, 13 REMU; these SHALL go IDLE->BUSY.
REQ-026 Multi-cycle ops SHALL iterate one bit per cycle: exactly XLEN cycles in BUSY, then DONE; out_valid is asserted XLEN+1 cycles after accept.
REQ-027 DIVU with divisor 0 SHALL give all-ones; REMU with divisor 0 SHALL give the dividend.
REQ-028 Op codes 14-15, and 10-13 when MULDIV_EN=0, SHALL complete as single-cycle ops with result 0.
REQ-029 In DONE, result and zero_flag SHALL hold stable until out_ready=1, then return to IDLE in the next cycle.
REQ-030 At the output handshake, if wb_en && rd!=0, the block SHALL write result to reg[rd].
REQ-031 wr_en SHALL write reg[wr_addr] in any state; writes to register 0 are ignored.
REQ-032 If wr_en and writeback target the same register in the same cycle, wr_data SHALL win; different targets both write.
REQ-033 in_valid SHALL be ignored outside IDLE; no queuing.

Reset
REQ-034 When rst=1, the block SHALL enter IDLE at the next edge and clear all registers, result and the iteration counter to 0.
REQ-035 After reset: in_ready=1, out_valid=0, busy=0, result=0, zero_flag=1.
REQ-036 rst SHALL abort any BUSY or DONE operation with no writeback; rst overrides wr_en.

Verification
REQ-037 Preload x1=5, x2=3; ADD rs1=1, rs2=2 -> result=8, zero_flag=0, out_valid 1 cycle after accept.
REQ-038 SUB x1,x1 -> result=0, zero_flag=1; ADD x1 with imm=4, alu_src=1, wb_en, rd=3; then ADD x3,x0 -> result=9.
REQ-039 x1=0xFFFFFFFF, x2=3: MUL -> 0xFFFFFFFD and MULHU -> 2; out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 throughout.
REQ-040 DIVU 100/7 -> 14 and REMU -> 2; DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7.
REQ-041 out_ready held 0 for 5 cycles in DONE -> result stable, in_valid ignored; wr_en and writeback to the same rd in one cycle -> wr_data stored.
REQ-042 rst pulsed at cycle 10 of a MUL -> next cycle in_ready=1, out_valid=0, busy=0, x1 reads 0, no writeback.
